// File: rtl/switch_debounce_pkg.sv
// Shared types and defaults for the slide-switch debouncer.
package switch_debounce_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // 10 ms at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/switch_debounce_bit.sv
// Per-bit two-flop synchronizer plus stability counter; flags when a new level has held long enough.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    input  logic i_level,
    input  logic i_run,
    output logic o_sync,
    output logic o_accept
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_last;

    assign w_diff   = (r_sync != i_level);
    assign w_last   = (r_cnt == LAST);
    assign o_sync   = r_sync;
    assign o_accept = i_run & w_diff & w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            // Clearing on acceptance keeps the counter from ever passing LAST.
            if (!i_run || !w_diff || w_last)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Slide-switch debouncer feeding a PIO in_port; optional sticky edge/irq logic under SWITCH_DEBOUNCE_EDGE_IRQ_EN.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_valid,
    output logic [WIDTH-1:0] rise_pulse,
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
    input  logic [WIDTH-1:0] edge_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    state_t           r_state;
    logic [CW-1:0]    r_icnt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic             w_run;

    assign w_run  = (r_state == ST_RUN);
    assign w_rise = w_accept & w_sync;
    assign w_fall = w_accept & ~w_sync;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .i_raw   (sw_raw[g]),
            .i_level (sw_out[g]),
            .i_run   (w_run),
            .o_sync  (w_sync[g]),
            .o_accept(w_accept[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_icnt     <= '0;
            r_prev     <= '0;
            sw_out     <= '0;
            sw_valid   <= 1'b0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            rise_pulse <= w_rise;
            fall_pulse <= w_fall;
            case (r_state)
                ST_INIT: begin
                    r_prev <= w_sync;
                    // The cycle a new vector first appears already counts as stable cycle one.
                    if (w_sync != r_prev) begin
                        r_icnt <= CW'(1);
                    end else if (r_icnt == LAST) begin
                        r_icnt   <= '0;
                        sw_out   <= w_sync;
                        sw_valid <= 1'b1;
                        r_state  <= ST_RUN;
                    end else begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    sw_out <= sw_out ^ w_accept;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= '0;
            irq    <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~edge_clr) | w_rise | w_fall;
            irq    <= |(r_edge & irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with WIDTH=3, DEBOUNCE_CYCLES=4.
module tb_switch_debounce;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] sw_raw = 3'b101;
    logic [2:0] sw_out;
    logic       sw_valid;
    logic [2:0] rise_pulse;
    logic [2:0] fall_pulse;
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
    logic [2:0] edge_clr = 3'b000;
    logic [2:0] irq_mask = 3'b000;
    logic       irq;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH          (3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_raw    (sw_raw),
        .sw_out    (sw_out),
        .sw_valid  (sw_valid),
        .rise_pulse(rise_pulse),
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
        .edge_clr  (edge_clr),
        .irq_mask  (irq_mask),
        .irq       (irq),
`endif
        .fall_pulse(fall_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with 101 on the pins.
        step(2);
        check("rst_out", 32'(sw_out), 32'h0);
        check("rst_valid", 32'(sw_valid), 32'h0);
        reset_n = 1'b1;
        step(5);
        check("init5_valid", 32'(sw_valid), 32'h0);
        check("init5_out", 32'(sw_out), 32'h0);
        step(1);
        check("init6_valid", 32'(sw_valid), 32'h1);
        check("init6_out", 32'(sw_out), 32'h5);
        check("init6_rise", 32'(rise_pulse), 32'h0);
        check("init6_fall", 32'(fall_pulse), 32'h0);

        // 101 -> 000
        sw_raw = 3'b000;
        step(5);
        check("f5_out", 32'(sw_out), 32'h5);
        step(1);
        check("f6_out", 32'(sw_out), 32'h0);
        check("f6_fall", 32'(fall_pulse), 32'h5);
        step(1);
        check("f7_fall", 32'(fall_pulse), 32'h0);

        // 000 -> 001
        sw_raw = 3'b001;
        step(5);
        check("r5_out", 32'(sw_out), 32'h0);
        check("r5_rise", 32'(rise_pulse), 32'h0);
        step(1);
        check("r6_out", 32'(sw_out), 32'h1);
        check("r6_rise", 32'(rise_pulse), 32'h1);
        step(1);
        check("r7_rise", 32'(rise_pulse), 32'h0);

        // 3-cycle glitch on bit 1
        sw_raw = 3'b011;
        step(3);
        sw_raw = 3'b001;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("glitch_out", 32'(sw_out), 32'h1);
            check("glitch_pulse", 32'({rise_pulse, fall_pulse}), 32'h0);
        end

        // 001 -> 111, then 111 -> 000
        sw_raw = 3'b111;
        step(6);
        check("all_rise", 32'(rise_pulse), 32'h6);
        check("all_out", 32'(sw_out), 32'h7);
        sw_raw = 3'b000;
        step(6);
        check("all_fall", 32'(fall_pulse), 32'h7);
        check("all0_out", 32'(sw_out), 32'h0);
        step(1);
        check("all_fall_end", 32'(fall_pulse), 32'h0);

        // Reset during a pending 000 -> 010 change (count at 2).
        sw_raw = 3'b010;
        step(4);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(sw_valid), 32'h0);
        check("mid_rst_out", 32'(sw_out), 32'h0);
        step(2);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("reinit_valid", 32'(sw_valid), 32'h0);
            check("reinit_out", 32'(sw_out), 32'h0);
            check("reinit_pulse", 32'({rise_pulse, fall_pulse}), 32'h0);
        end
        step(1);
        check("reacc_valid", 32'(sw_valid), 32'h1);
        check("reacc_out", 32'(sw_out), 32'h2);
        check("reacc_pulse", 32'({rise_pulse, fall_pulse}), 32'h0);

`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
        irq_mask = 3'b010;
        sw_raw = 3'b000;
        step(6);
        check("irq_fall", 32'(fall_pulse), 32'h2);
        check("irq_pre", 32'(irq), 32'h0);
        step(1);
        check("irq_set", 32'(irq), 32'h1);
        edge_clr = 3'b010;
        step(1);
        edge_clr = 3'b000;
        check("irq_lag", 32'(irq), 32'h1);
        step(1);
        check("irq_clr", 32'(irq), 32'h0);
        sw_raw = 3'b010;
        step(5);
        edge_clr = 3'b010;
        step(1);
        edge_clr = 3'b000;
        check("irq_rise", 32'(rise_pulse), 32'h2);
        check("irq_pre2", 32'(irq), 32'h0);
        step(1);
        check("irq_setwins", 32'(irq), 32'h1);
        step(2);
        check("irq_sticky", 32'(irq), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 3, number of slide-switch bits fed to the downstream PIO input port.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), consecutive stable cycles required to accept a new level; legal range 2..2^24-1.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sw_raw, input, WIDTH, asynchronous raw switch pins.
REQ-006 SHALL have port sw_out, output, WIDTH, debounced level; connects to the PIO in_port.
REQ-007 SHALL have port sw_valid, output, 1, high once the initial level has been accepted.
REQ-008 SHALL have port rise_pulse, output, WIDTH, one-cycle pulse per bit on an accepted 0->1 change.
REQ-009 SHALL have port fall_pulse, output, WIDTH, one-cycle pulse per bit on an accepted 1->0 change.
REQ-010 SHALL have ports edge_clr (input, WIDTH, write-1-to-clear strobe), irq_mask (input, WIDTH) and irq (output, 1), present only under the REQ-030 macro.

Function
REQ-011 SHALL pass each sw_raw bit through a two-flop synchronizer; only the second flop output (sync) feeds the logic.
REQ-012 SHALL keep, per bit, a counter of width clog2(DEBOUNCE_CYCLES) that increments while sync differs from the accepted level and clears when they are equal.
REQ-013 SHALL update the accepted bit and clear its counter on the cycle the counter reaches DEBOUNCE_CYCLES-1 while sync still differs.
REQ-014 SHALL produce a latency of exactly 2+DEBOUNCE_CYCLES clk cycles from a clean sw_raw change to the sw_out change.
REQ-015 SHALL restart counting from zero on any glitch shorter than DEBOUNCE_CYCLES; sw_out is then unchanged.
REQ-016 SHALL assert rise_pulse[i]/fall_pulse[i] in the same cycle sw_out[i] changes, for one cycle only.
REQ-017 SHALL treat bits independently; simultaneous acceptance on several bits yields simultaneous pulses.
REQ-018 SHALL implement a two-state FSM: INIT (after reset) and RUN.
REQ-019 SHALL, in INIT, count DEBOUNCE_CYCLES cycles of unchanged sync (whole vector); any change restarts the count; on completion load sw_out from sync, assert sw_valid and go to RUN with no pulses emitted.
REQ-020 SHALL, in RUN, apply REQ-012..REQ-017; RUN never returns to INIT except through reset.
REQ-021 SHALL hold sw_out at all zeros and all pulses low while in INIT.
REQ-022 SHALL saturate no counter beyond DEBOUNCE_CYCLES-1 (no wrap-around).

Reset
REQ-023 SHALL asynchronously clear synchronizer flops, counters, sw_out, sw_valid, pulses and edge register, and enter INIT, on reset_n low.
REQ-024 SHALL abandon any in-progress count when reset is asserted mid-operation; no pulse follows reset release until RUN acceptance.
REQ-025 SHALL release synchronously (first counting edge is the first clk rising edge after reset_n high).

Configuration
REQ-030 SHALL compile in edge capture/interrupt only when SWITCH_DEBOUNCE_EDGE_IRQ_EN is defined.
REQ-031 SHALL, with the macro, set sticky edge bit i on rise_pulse[i] or fall_pulse[i], clear it on edge_clr[i], set winning on simultaneous set/clear, and drive irq = OR(edge & irq_mask) registered one cycle later.
REQ-032 SHALL, without the macro, omit edge_clr, irq_mask, irq and the edge register entirely.

Structure
REQ-033 SHALL place the FSM state enum (INIT, RUN) and the default DEBOUNCE_CYCLES constant in package switch_debounce_pkg.
REQ-034 SHALL implement the per-bit synchronizer+counter as sub-module debounce_bit, instantiated WIDTH times.

Verification (bench uses DEBOUNCE_CYCLES=4, WIDTH=3)
REQ-040 Reset with sw_raw=3'b101 held -> sw_valid and sw_out=3'b101 at cycle 2+4 after release, no pulses.
REQ-041 In RUN, sw_raw 3'b000->3'b001 clean -> sw_out[0]=1 and rise_pulse=3'b001 for one cycle exactly 6 cycles later.
REQ-042 Glitch on sw_raw[1] lasting 3 cycles -> sw_out, pulses unchanged.
REQ-043 sw_raw 3'b111->3'b000 simultaneously -> fall_pulse=3'b111 for one cycle, sw_out=0.
REQ-044 reset_n pulsed low at count 2 of a pending change -> FSM in INIT, no pulse, sw_out=0 until re-acceptance.
REQ-045 With macro, irq_mask=3'b010, rise on bit1 -> irq high one cycle after pulse; edge_clr=3'b010 coincident with new pulse on bit1 -> bit stays set.
